// File: rtl/noc_pkg.sv
// noc_pkg: shared router parameters, port indices and arbiter state type
package noc_pkg;
  localparam int N_PORTS = 5;
  localparam int FLIT_W = 34;
  localparam int IDX_W = 3;
  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_S = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;
  typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin picker, lowest index at or above ptr, else lowest overall
module rr_pick import noc_pkg::*; (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N_PORTS-1:0] win,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any
);
  logic [N_PORTS-1:0] masked;
  logic [IDX_W-1:0] m_idx, u_idx;
  always_comb begin
    masked = '0;
    m_idx = '0;
    u_idx = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      masked[i] = req[i] && (i >= int'(ptr));
      if (masked[i]) m_idx = IDX_W'(i);
      if (req[i]) u_idx = IDX_W'(i);
    end
    any = |req;
    win_idx = |masked ? m_idx : u_idx;
    win = any ? N_PORTS'(1) << win_idx : '0;
  end
endmodule

// File: rtl/output_arbiter.sv
// output_arbiter: packet-locked round-robin arbiter and flit mux for one output port
module output_arbiter import noc_pkg::*; (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_PORTS-1:0]        req_i,
  input  logic [N_PORTS-1:0]        tail_i,
  input  logic [N_PORTS*FLIT_W-1:0] flit_i,
  input  logic                      ready_i,
  output logic [N_PORTS-1:0]        grant_o,
  output logic [2:0]                sel_o,
  output logic                      valid_o,
  output logic [FLIT_W-1:0]         flit_o,
  output logic [N_PORTS-1:0]        pop_o
);
  state_t state;
  logic [IDX_W-1:0] own, ptr, win_idx;
  logic [N_PORTS-1:0] win;
  logic any, busy, transfer;
  rr_pick u_pick (.req(req_i), .ptr(ptr), .win(win), .win_idx(win_idx), .any(any));
  // gating with rst_ni keeps a reset cycle from consuming a flit
  assign busy = (state == BUSY) && rst_ni;
  assign valid_o = busy && req_i[own];
  assign flit_o = busy ? flit_i[own*FLIT_W +: FLIT_W] : '0;
  assign transfer = valid_o && ready_i;
  assign pop_o = transfer ? grant_o : '0;
  assign sel_o = own;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      own <= '0;
      ptr <= '0;
      grant_o <= '0;
    end else if (state == IDLE) begin
      if (any) begin
        state <= BUSY;
        own <= win_idx;
        grant_o <= win;
      end
    end else if (transfer && tail_i[own]) begin
      state <= IDLE;
      own <= '0;
      grant_o <= '0;
      ptr <= (own == IDX_W'(N_PORTS - 1)) ? '0 : own + 3'd1;
    end
  end
endmodule

// File: tb/tb_output_arbiter.sv
// tb_output_arbiter: directed vector table plus hand sequences for output_arbiter
module tb_output_arbiter;
  import noc_pkg::*;
  typedef struct {
    logic rst_n;
    logic [4:0] req;
    logic [4:0] tail;
    logic ready;
    logic [4:0] grant;
    logic [2:0] sel;
    logic valid;
    logic [4:0] pop;
    int fown;
    logic [2:0] ptr;
  } vec_t;

  logic clk = 0;
  logic rst_ni;
  logic [N_PORTS-1:0] req_i, tail_i, grant_o, pop_o;
  logic [N_PORTS*FLIT_W-1:0] flit_i;
  logic ready_i, valid_o;
  logic [2:0] sel_o;
  logic [FLIT_W-1:0] flit_o;
  int checks = 0;
  int failures = 0;
  vec_t v[22];

  output_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .tail_i(tail_i), .flit_i(flit_i),
    .ready_i(ready_i), .grant_o(grant_o), .sel_o(sel_o), .valid_o(valid_o),
    .flit_o(flit_o), .pop_o(pop_o)
  );

  always #5 clk = ~clk;

  function automatic logic [FLIT_W-1:0] pflit(int p);
    logic [1:0] hi;
    hi = 2'(p);
    return (p < 0) ? '0 : {hi, 32'hA5A5_0000 | 32'(p)};
  endfunction

  task automatic chk(string name, int row, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, exp);
    end
  endtask

  task automatic run(vec_t e, int row);
    rst_ni = e.rst_n;
    req_i = e.req;
    tail_i = e.tail;
    ready_i = e.ready;
    @(negedge clk);
    chk("grant", row, 64'(grant_o), 64'(e.grant));
    chk("sel", row, 64'(sel_o), 64'(e.sel));
    chk("valid", row, 64'(valid_o), 64'(e.valid));
    chk("pop", row, 64'(pop_o), 64'(e.pop));
    chk("flit", row, 64'(flit_o), 64'(pflit(e.fown)));
    chk("ptr", row, 64'(dut.ptr), 64'(e.ptr));
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < N_PORTS; k++) flit_i[k*FLIT_W +: FLIT_W] = pflit(k);
    // 3-flit packet on port 2, then single-flit on port 4
    v[0]  = '{1, 5'b10100, 5'b00000, 1, 5'b00000, 0, 0, 5'b00000, -1, 0};
    v[1]  = '{1, 5'b10100, 5'b00000, 1, 5'b00100, 2, 1, 5'b00100,  2, 0};
    v[2]  = '{1, 5'b10100, 5'b00000, 1, 5'b00100, 2, 1, 5'b00100,  2, 0};
    v[3]  = '{1, 5'b10100, 5'b00100, 1, 5'b00100, 2, 1, 5'b00100,  2, 0};
    v[4]  = '{1, 5'b10000, 5'b00000, 1, 5'b00000, 0, 0, 5'b00000, -1, 3};
    v[5]  = '{1, 5'b10000, 5'b10000, 1, 5'b10000, 4, 1, 5'b10000,  4, 3};
    v[6]  = '{1, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 5'b00000, -1, 0};
    // port 1 stalled by ready_i for four cycles
    v[7]  = '{1, 5'b00010, 5'b00000, 0, 5'b00000, 0, 0, 5'b00000, -1, 0};
    v[8]  = '{1, 5'b00010, 5'b00000, 0, 5'b00010, 1, 1, 5'b00000,  1, 0};
    v[9]  = '{1, 5'b00010, 5'b00000, 0, 5'b00010, 1, 1, 5'b00000,  1, 0};
    v[10] = '{1, 5'b00010, 5'b00000, 0, 5'b00010, 1, 1, 5'b00000,  1, 0};
    v[11] = '{1, 5'b00010, 5'b00000, 0, 5'b00010, 1, 1, 5'b00000,  1, 0};
    v[12] = '{1, 5'b00010, 5'b00010, 1, 5'b00010, 1, 1, 5'b00010,  1, 0};
    v[13] = '{1, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 5'b00000, -1, 2};
    // port 3 bubble while port 0 waits
    v[14] = '{1, 5'b01000, 5'b00000, 1, 5'b00000, 0, 0, 5'b00000, -1, 2};
    v[15] = '{1, 5'b01001, 5'b00000, 1, 5'b01000, 3, 1, 5'b01000,  3, 2};
    v[16] = '{1, 5'b00001, 5'b00000, 1, 5'b01000, 3, 0, 5'b00000,  3, 2};
    v[17] = '{1, 5'b00001, 5'b00000, 1, 5'b01000, 3, 0, 5'b00000,  3, 2};
    v[18] = '{1, 5'b01001, 5'b01000, 1, 5'b01000, 3, 1, 5'b01000,  3, 2};
    v[19] = '{1, 5'b00001, 5'b00000, 1, 5'b00000, 0, 0, 5'b00000, -1, 4};
    v[20] = '{1, 5'b00001, 5'b00001, 1, 5'b00001, 0, 1, 5'b00001,  0, 4};
    v[21] = '{1, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 5'b00000, -1, 1};
    rst_ni = 0;
    req_i = '0;
    tail_i = '0;
    ready_i = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 22; i++) run(v[i], i);
    // all ports request single-flit packets continuously after a fresh reset
    run('{0, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 5'b00000, -1, 1}, 100);
    for (int k = 0; k < 6; k++) begin
      run('{1, 5'b11111, 5'b11111, 1, 5'b00000, 0, 0, 5'b00000, -1, 3'(k % 5)}, 200 + 2*k);
      run('{1, 5'b11111, 5'b11111, 1, 5'b00001 << (k % 5), 3'(k % 5), 1,
            5'b00001 << (k % 5), k % 5, 3'(k % 5)}, 201 + 2*k);
    end
    // reset during flit 2 of a packet on port 2 with ptr at 1
    run('{1, 5'b00100, 5'b00000, 1, 5'b00000, 0, 0, 5'b00000, -1, 1}, 300);
    run('{1, 5'b00100, 5'b00000, 1, 5'b00100, 2, 1, 5'b00100,  2, 1}, 301);
    run('{0, 5'b00100, 5'b00000, 1, 5'b00100, 2, 0, 5'b00000, -1, 1}, 302);
    run('{1, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 5'b00000, -1, 0}, 303);
    run('{1, 5'b11111, 5'b00000, 1, 5'b00000, 0, 0, 5'b00000, -1, 0}, 304);
    run('{1, 5'b11111, 5'b00000, 1, 5'b00001, 0, 1, 5'b00001,  0, 0}, 305);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/output_arbiter.md
# output_arbiter

Round-robin, packet-locked arbiter for one router output port. It shares the output link between the five input ports (N, E, S, W, Local) and drives the crossbar select for that output. A grant is held from head flit to tail flit (wormhole), so flits of different packets never interleave on the link. One instance sits per output port, between the input-port routing logic and the output link or downstream buffer.

## Interface
- N_PORTS, 5, number of requesting input ports; bit index = port index.
- FLIT_W, 34, flit width in bits, including the header/tail flags carried in the payload.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset, synchronous, active-low.
- req_i  input  N_PORTS  per-port request: input port has a flit for this output.
- tail_i  input  N_PORTS  per-port flag: the presented flit is the packet's tail.
- flit_i  input  N_PORTS*FLIT_W  per-port flits; port k occupies bits [k*FLIT_W +: FLIT_W].
- ready_i  input  1  downstream can accept a flit this cycle.
- grant_o  output  N_PORTS  one-hot current owner; all zero when idle.
- sel_o  output  3  binary index of the owner; 0 when idle.
- valid_o  output  1  flit_o is valid this cycle.
- flit_o  output  FLIT_W  flit of the owning port; all zero when idle.
- pop_o  output  N_PORTS  one-hot: the owner's flit is consumed this cycle.

## Operation
- The controller has two states:
  - IDLE: no owner.
  - BUSY: owner register `own` holds the granted port.
- Round-robin pointer `ptr` (0..N_PORTS-1) names the first port searched. The search order is ptr, ptr+1, … wrapping modulo N_PORTS. The first port with req_i set wins.
- IDLE → BUSY: when any req_i bit is set, the winner is registered into `own`. grant_o and sel_o become valid on the next cycle.
- BUSY outputs:
  - valid_o = req_i[own].
  - flit_o = flit_i[own] (combinational mux).
  - transfer = valid_o & ready_i.
  - pop_o[own] = transfer.
- BUSY → IDLE: on a transfer with tail_i[own]=1. On the same edge, `ptr` ← (own+1) mod N_PORTS.
- While BUSY, requests from other ports are ignored. The owner keeps the grant even if req_i[own] drops mid-packet (upstream bubble). valid_o goes low and the arbiter waits.
- A single-flit packet (head = tail) takes one BUSY cycle if ready_i=1.
- `ptr` changes only on tail transfer, never on a grant alone.

## Timing
- Reset values, applied while rst_ni=0 at the clock edge:
  - state IDLE, ptr 0.
  - grant_o 0, sel_o 0, valid_o 0, pop_o 0, flit_o 0.
- Reset asserted mid-packet aborts the packet immediately. No pop_o occurs in the reset cycle.
- Request to grant latency: 1 cycle. The first flit can transfer in the first BUSY cycle.
- After a tail transfer there is one IDLE cycle before the next grant, so the maximum link utilisation is L/(L+1) for L-flit packets.
- A tail transfer and new requests in the same cycle: the new requests are arbitrated in the following IDLE cycle using the updated ptr.
- ready_i low in BUSY: hold the flit with no pop_o and no state change.
- All outputs except flit_o, valid_o and pop_o are registered. Those three are combinational from req_i, ready_i and flit_i through the owner mux.

## Structure
- Shared package `noc_pkg`:
  - N_PORTS and FLIT_W.
  - port index constants (PORT_N=0, PORT_E=1, PORT_S=2, PORT_W=3, PORT_L=4).
  - the state enum {IDLE, BUSY}.
- Sub-module `rr_pick`, purely combinational:
  - inputs: req[N_PORTS], ptr.
  - outputs: one-hot win, win_idx, any.
  - implementation: masked pass (ports ≥ ptr) falling back to an unmasked pass, each a lowest-index-first picker.
- The top level holds the FSM, `own`, `ptr` and the flit mux.

## Test plan
- Reset, then req_i=5'b10100 → the cycle after: grant_o=5'b00100, sel_o=2. A 3-flit packet with ready_i=1 gives pop_o[2] on 3 consecutive cycles. Then 1 IDLE cycle, then grant_o=5'b10000, ptr=3.
- All ports request continuously with single-flit packets → grants in order 0,1,2,3,4,0 with one IDLE cycle between each.
- Port 1 owns, ready_i=0 for 4 cycles → valid_o=1, pop_o=0, flit_o stable. Then ready_i=1 → pop_o=5'b00010.
- Port 3 owns, req_i[3] drops for 2 cycles mid-packet while port 0 requests → grant stays 5'b01000, valid_o=0. The packet then completes before port 0 is granted.
- rst_ni=0 during flit 2 of a 4-flit packet → all outputs 0 and ptr=0 at the next edge. After release, req_i=5'b11111 → port 0 granted.
- Single-flit packet on port 4 with ready_i=1 → exactly one pop_o=5'b10000, then IDLE and ptr=0.
